// File: rtl/ram_pkg.sv
// Shared constants and request typedef for the multi-port RAM.
// Latency: none (types and constants only).
// Backpressure: none; the RAM ports have no flow control.
package ram_pkg;

  // Access enable is active low.
  localparam logic EN_ACTIVE = 1'b0;
  localparam logic EN_IDLE   = 1'b1;

  // Port direction encoding.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Per-port request control fields.
  typedef struct packed {
    logic en_;
    logic rw_;
  } ram_port_t;

  function automatic logic is_read(input ram_port_t req);
    return (req.en_ == EN_ACTIVE) && (req.rw_ == RW_READ);
  endfunction

  function automatic logic is_write(input ram_port_t req);
    return (req.en_ == EN_ACTIVE) && (req.rw_ == RW_WRITE);
  endfunction

endpackage

// File: rtl/ram_rdport.sv
// One read port: address mux with zero for out-of-range, optional output register.
// Latency: 0 cycles (OUTREG=0) or 1 cycle (OUTREG=1, holds between reads).
// Backpressure: none; a read is accepted every cycle.
module ram_rdport
  import ram_pkg::*;
#(
  parameter int DATA   = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR   = 2,
  parameter int OUTREG = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  ram_port_t       req,
  input  logic [ADDR-1:0] addr,
  input  logic [DATA-1:0] mem [DEPTH],
  output logic [DATA-1:0] rdata
);

  localparam logic [ADDR:0] LIMIT = (ADDR+1)'(DEPTH);

  logic [DATA-1:0] sel;

  // Array lookup; addresses past the last word read as zero.
  always_comb begin
    sel = '0;
    if ({1'b0, addr} < LIMIT) sel = mem[addr];
  end

  generate
    if (OUTREG != 0) begin : g_reg
      // Registered read data: load on a read cycle, hold otherwise.
      always_ff @(posedge clk) begin
        if (reset)             rdata <= '0;
        else if (is_read(req)) rdata <= sel;
      end
    end else begin : g_comb
      // Combinational read data follows the address regardless of en_/rw_.
      assign rdata = sel;
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, reset, req};
    end
  endgenerate

endmodule

// File: rtl/ram_multiport.sv
// Multi-port synchronous-write RAM; lowest-numbered port wins write conflicts.
// Latency: write stored at the edge; read 0 (OUTREG=0) or 1 (OUTREG=1) cycles; no bypass.
// Backpressure: none. Macro RAM_RESET_CLEAR_EN makes reset clear all words.
module ram_multiport
  import ram_pkg::*;
#(
  parameter  int DATA   = 32,
  parameter  int DEPTH  = 4,
  parameter  int PORT   = 2,
  parameter  int OUTREG = 0,
  localparam int ADDR   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PORT-1:0]           en_,
  input  logic [PORT-1:0]           rw_,
  input  logic [PORT-1:0][ADDR-1:0] addr,
  input  logic [PORT-1:0][DATA-1:0] wdata,
  output logic [PORT-1:0][DATA-1:0] rdata
);

  localparam logic [ADDR:0] LIMIT = (ADDR+1)'(DEPTH);

  logic [DATA-1:0] mem [DEPTH];
  ram_port_t       req [PORT];
  logic [PORT-1:0] wr_ok;

  // Qualify each write: enabled, write direction, address inside the array.
  always_comb begin
    wr_ok = '0;
    for (int p = 0; p < PORT; p++) begin
      req[p]   = '{en_: en_[p], rw_: rw_[p]};
      wr_ok[p] = is_write(req[p]) && ({1'b0, addr[p]} < LIMIT);
    end
  end

`ifdef RAM_RESET_CLEAR_EN
  // Memory update; reset clears every word; highest port applied first so port 0 lands last.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int p = PORT-1; p >= 0; p--)
        if (wr_ok[p]) mem[addr[p]] <= wdata[p];
    end
  end
`else
  // Memory update; reset only blocks writes; highest port applied first so port 0 lands last.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int p = PORT-1; p >= 0; p--)
        if (wr_ok[p]) mem[addr[p]] <= wdata[p];
    end
  end
`endif

  generate
    for (genvar g = 0; g < PORT; g++) begin : g_rd
      ram_rdport #(
        .DATA  (DATA),
        .DEPTH (DEPTH),
        .ADDR  (ADDR),
        .OUTREG(OUTREG)
      ) u_rdport (
        .clk  (clk),
        .reset(reset),
        .req  (req[g]),
        .addr (addr[g]),
        .mem  (mem),
        .rdata(rdata[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_ram_multiport.sv
// Directed bench: three RAM instances (comb DEPTH=4, registered DEPTH=4, comb DEPTH=3)
// share one stimulus stream; expected values are hand-computed constants.
module tb_ram_multiport;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       en_;
  logic [1:0]       rw_;
  logic [1:0][1:0]  addr;
  logic [1:0][31:0] wdata;
  logic [1:0][31:0] rd_c;   // OUTREG=0, DEPTH=4
  logic [1:0][31:0] rd_r;   // OUTREG=1, DEPTH=4
  logic [1:0][31:0] rd_s;   // OUTREG=0, DEPTH=3

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_multiport #(.DATA(32), .DEPTH(4), .PORT(2), .OUTREG(0)) u_comb (
    .clk(clk), .reset(reset), .en_(en_), .rw_(rw_), .addr(addr), .wdata(wdata), .rdata(rd_c));
  ram_multiport #(.DATA(32), .DEPTH(4), .PORT(2), .OUTREG(1)) u_reg (
    .clk(clk), .reset(reset), .en_(en_), .rw_(rw_), .addr(addr), .wdata(wdata), .rdata(rd_r));
  ram_multiport #(.DATA(32), .DEPTH(3), .PORT(2), .OUTREG(0)) u_small (
    .clk(clk), .reset(reset), .en_(en_), .rw_(rw_), .addr(addr), .wdata(wdata), .rdata(rd_s));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] small_exp [3];

  initial begin
    reset = 1'b1; en_ = 2'b11; rw_ = 2'b11; addr = '0; wdata = '0;
    step();
    check("reset_rdreg0", rd_r[0], 32'h0);
    check("reset_rdreg1", rd_r[1], 32'h0);
    reset = 1'b0;

`ifdef RAM_RESET_CLEAR_EN
    for (int a = 0; a < 4; a++) begin
      en_ = 2'b00; rw_ = 2'b11; addr[0] = 2'(a); addr[1] = 2'(a);
      #1;
      check("reset_mem_p0", rd_c[0], 32'h0);
      check("reset_mem_p1", rd_c[1], 32'h0);
    end
`endif

    // Fill all words so later reads never see uninitialised storage.
    en_ = 2'b00; rw_ = 2'b00; addr[0] = 2'd0; addr[1] = 2'd1;
    wdata[0] = 32'h10; wdata[1] = 32'h11;
    step();
    addr[0] = 2'd2; addr[1] = 2'd3; wdata[0] = 32'h12; wdata[1] = 32'h13;
    step();

    // Port 0 writes addr 0, then port 1 reads it.
    en_ = 2'b10; rw_ = 2'b10; addr[0] = 2'd0; wdata[0] = 32'hdaedbeef;
    step();
    en_ = 2'b01; rw_ = 2'b11; addr[1] = 2'd0;
    #1;
    check("wr_rd_comb", rd_c[1], 32'hdaedbeef);
    check("wr_rd_reg_before_edge", rd_r[1], 32'h0);
    step();
    check("wr_rd_reg_after_edge", rd_r[1], 32'hdaedbeef);

    // Registered port 0 holds through idle cycles even as the address moves.
    en_ = 2'b10; rw_ = 2'b11; addr[0] = 2'd0;
    step();
    check("hold_load", rd_r[0], 32'hdaedbeef);
    en_ = 2'b11; addr[0] = 2'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_idle", rd_r[0], 32'hdaedbeef);
    end

    // Same-cycle writes to one address: port 0 wins.
    en_ = 2'b00; rw_ = 2'b00; addr[0] = 2'd2; addr[1] = 2'd2;
    wdata[0] = 32'h11111111; wdata[1] = 32'h22222222;
    step();
    rw_ = 2'b11;
    #1;
    check("conflict_comb_p0", rd_c[0], 32'h11111111);
    check("conflict_comb_p1", rd_c[1], 32'h11111111);
    step();
    check("conflict_reg_p0", rd_r[0], 32'h11111111);

    // Read-during-write returns old data; new data follows.
    en_ = 2'b10; rw_ = 2'b10; addr[0] = 2'd1; wdata[0] = 32'hAAAAAAAA;
    step();
    en_ = 2'b00; rw_ = 2'b10; addr[0] = 2'd1; addr[1] = 2'd1; wdata[0] = 32'h55555555;
    #1;
    check("rdw_comb_old", rd_c[1], 32'hAAAAAAAA);
    step();
    check("rdw_reg_old", rd_r[1], 32'hAAAAAAAA);
    check("rdw_comb_new", rd_c[1], 32'h55555555);
    en_ = 2'b01; rw_ = 2'b11;
    step();
    check("rdw_reg_new", rd_r[1], 32'h55555555);

    // Out-of-range on the DEPTH=3 instance: write to addr 3 dropped, read gives 0.
    en_ = 2'b10; rw_ = 2'b10; addr[0] = 2'd3; wdata[0] = 32'hFFFFFFFF;
    step();
    small_exp[0] = 32'hdaedbeef;
    small_exp[1] = 32'h55555555;
    small_exp[2] = 32'h11111111;
    for (int a = 0; a < 3; a++) begin
      en_ = 2'b00; rw_ = 2'b11; addr[0] = 2'd3; addr[1] = 2'(a);
      #1;
      check("oob_read_zero", rd_s[0], 32'h0);
      check("oob_inrange_unchanged", rd_s[1], small_exp[a]);
    end
    check("depth4_addr3_written", rd_c[0], 32'hFFFFFFFF);

    // Reset beats a same-cycle read and clears the output registers.
    reset = 1'b1; en_ = 2'b00; rw_ = 2'b11; addr[0] = 2'd0; addr[1] = 2'd1;
    step();
    check("reset_clear_rdreg0", rd_r[0], 32'h0);
    check("reset_clear_rdreg1", rd_r[1], 32'h0);
    reset = 1'b0;

`ifdef RAM_RESET_CLEAR_EN
    for (int a = 0; a < 4; a++) begin
      en_ = 2'b00; rw_ = 2'b11; addr[0] = 2'(a); addr[1] = 2'(a);
      #1;
      check("rereset_mem_p0", rd_c[0], 32'h0);
      check("rereset_mem_p1", rd_c[1], 32'h0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_multiport.md
# ram_multiport

Parameterised multi-port synchronous-write RAM used as generic storage (register files, small buffers, tables) across the design. Every port reads or writes independently each cycle. Read data is combinational or registered, selected by a parameter. Write-port conflicts resolve by a fixed priority.

## Interface
- `DATA`, 32: word width in bits.
- `DEPTH`, 4: number of words; need not be a power of two.
- `PORT`, 2: number of independent read/write ports.
- `OUTREG`, 0 (Disable): 1 = registered read data; 0 = combinational read data.
- `ADDR`, `$clog2(DEPTH)`: address width, derived; not overridden.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en_`  in  `[PORT-1:0]`  per-port access enable, active low.
- `rw_`  in  `[PORT-1:0]`  per-port direction: 1 = read, 0 = write.
- `addr`  in  `[PORT-1:0][ADDR-1:0]`  per-port word address.
- `wdata`  in  `[PORT-1:0][DATA-1:0]`  per-port write data.
- `rdata`  out  `[PORT-1:0][DATA-1:0]`  per-port read data.

## Operation
- **Write:** port p writes when `en_[p]==0` and `rw_[p]==0`. `mem[addr[p]] <= wdata[p]` at the rising edge.
- **Read:** port p reads when `en_[p]==0` and `rw_[p]==1`.
- **Out-of-range address** (`addr >= DEPTH`):
  - A write is dropped.
  - A read returns 0.
- **Multiple writes to one address in the same cycle:** the lowest-numbered port wins. The other writes to that address are discarded.
- **OUTREG=0:**
  - `rdata[p] = mem[addr[p]]` combinationally, regardless of `en_` and `rw_`.
  - Consumers sample `rdata` only on read cycles.
- **OUTREG=1:**
  - `rdata[p]` is a register.
  - It loads `mem[addr[p]]` on a rising edge where port p reads.
  - It holds its value on idle and write cycles.
- **Read-during-write to the same address (any ports):**
  - Reads return the old contents; there is no bypass.
  - With OUTREG=0 the new value appears combinationally after the write edge.
- **Reset:**
  - Clears the `rdata` registers (OUTREG=1) to 0.
  - Clears memory per Configuration.
  - Reset takes priority over any same-cycle access, which is ignored.

## Timing
- Write latency: data is stored at edge N. An OUTREG=0 read in cycle N+1 returns it.
- Read latency:
  - OUTREG=0: 0 cycles; data is valid in the same cycle as the address.
  - OUTREG=1: 1 cycle; data is valid after the edge that sampled the read request and stays until the next read on that port.
- Reset values:
  - `rdata` = 0 (OUTREG=1).
  - `rdata` = contents of `mem[addr]` (OUTREG=0), i.e. 0 once memory is cleared.
- No handshake; every port accepts one access per cycle with no back-pressure.

## Configuration
- Macro: `RAM_RESET_CLEAR_EN`.
- **Defined:** `reset` clears every memory word to 0, in one cycle.
- **Undefined:** memory is not reset, and contents are undefined until written. Only the `rdata` registers are reset. This allows inference of block RAM.

## Structure
- Shared package `ram_pkg` holds:
  - the active-low enable/disable constants;
  - the Read(1)/Write(0) direction constants;
  - a `ram_port_t` helper typedef for per-port request fields.
- One natural sub-module, `ram_rdport`. It handles per-port read muxing, including the out-of-range zero.
- `ram_rdport` also contains the optional output register, generated on `OUTREG`.
- Write arbitration and the memory array stay in the top module.

## Test plan
- **Reset** (`RAM_RESET_CLEAR_EN` defined), OUTREG=0: hold `reset=1` one cycle, release, and read addresses 0–3 from both ports -> `rdata` = 0x00000000 everywhere.
- **Write then read across ports:**
  - Port 0 writes 0xdaedbeef to addr 0 for one cycle.
  - The next cycle, port 1 reads addr 0 -> `rdata[1]`=0xdaedbeef in that cycle (OUTREG=0), or one edge later (OUTREG=1).
- **Write conflict:** in the same cycle, port 0 writes 0x11111111 and port 1 writes 0x22222222, both to addr 2 -> a subsequent read of addr 2 returns 0x11111111.
- **Read-during-write, OUTREG=1:**
  - Set addr 1 = 0xAAAAAAAA.
  - In one cycle, port 0 writes 0x55555555 to addr 1 while port 1 reads addr 1 -> `rdata[1]`=0xAAAAAAAA.
  - The next read returns 0x55555555.
- **Hold, OUTREG=1:**
  - After port 0 reads 0xdaedbeef, deassert `en_[0]` for 5 cycles -> `rdata[0]` stays 0xdaedbeef.
  - Assert `reset` -> `rdata[0]` = 0 after the edge.
- **Out of range:** with DEPTH=3, write 0xFFFFFFFF to addr 3 and read addr 3 -> read returns 0; addresses 0–2 are unchanged.
